uart_periph: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/uart_periph.sv | 212 +++++++++++++++++++++
 tb/tb_uart_periph.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the MMIO UART peripheral
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_BUSY  = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead synchronous FIFO for received bytes
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign count = cnt;
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_periph.sv
// rtl/uart_periph.sv - 8N1 UART with RX FIFO; optional sticky error flags under UART_STATUS_EN
module uart_periph
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_we,
    output logic                   tx_busy,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_re,
    output logic                   uart_txd,
    input  logic                   uart_rxd
`ifdef UART_STATUS_EN
    ,
    output logic                   rx_overrun,
    output logic                   rx_frame_err,
    input  logic                   err_clr
`endif
);

    localparam int             CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF    = CW'(CLKS_PER_BIT / 2);

    tx_state_t                tx_state, tx_state_n;
    logic [CW-1:0]            tx_cnt, tx_cnt_n;
    logic [UART_DATA_W-1:0]   tx_shift, tx_shift_n;
    logic [2:0]               tx_idx, tx_idx_n;
    logic                     tx_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_idx   <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_shift <= tx_shift_n;
            tx_idx   <= tx_idx_n;
        end
    end

    assign tx_tick = (tx_cnt == CNT_MAX);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_shift_n = tx_shift;
        tx_idx_n   = tx_idx;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_we) begin
                    tx_state_n = TX_START;
                    tx_shift_n = tx_data;
                end
            end
            TX_START: if (tx_tick) begin
                tx_state_n = TX_DATA;
                tx_cnt_n   = '0;
                tx_idx_n   = '0;
            end
            TX_DATA: if (tx_tick) begin
                tx_cnt_n   = '0;
                tx_shift_n = tx_shift >> 1;
                if (tx_idx == 3'd7) tx_state_n = TX_STOP;
                else                tx_idx_n   = tx_idx + 1'b1;
            end
            TX_STOP: if (tx_tick) begin
                tx_state_n = TX_IDLE;
                tx_cnt_n   = '0;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Line level is decoded from state so reset forces it high without waiting a clock.
    assign uart_txd = (tx_state == TX_START) ? 1'b0 :
                      (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
    assign tx_busy  = (tx_state != TX_IDLE);

    logic                     rxd_meta, rxd_sync;
    rx_state_t                rx_state, rx_state_n;
    logic [CW-1:0]            rx_cnt, rx_cnt_n;
    logic [UART_DATA_W-1:0]   rx_shift, rx_shift_n;
    logic [2:0]               rx_idx, rx_idx_n;
    logic                     rx_hold, rx_hold_n;
    logic                     rx_tick;
    logic                     rx_push;
    logic                     rx_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_idx   <= '0;
            rx_hold  <= 1'b0;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_shift <= rx_shift_n;
            rx_idx   <= rx_idx_n;
            rx_hold  <= rx_hold_n;
        end
    end

    assign rx_tick = (rx_cnt == CNT_MAX);

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_shift_n = rx_shift;
        rx_idx_n   = rx_idx;
        rx_hold_n  = rx_hold;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                // Starting at half a bit puts every later expiry at mid-bit.
                if (!rxd_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = HALF;
                end
            end
            RX_START: if (rx_tick) begin
                rx_cnt_n   = '0;
                rx_idx_n   = '0;
                rx_state_n = rxd_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rxd_sync, rx_shift[UART_DATA_W-1:1]};
                if (rx_idx == 3'd7) rx_state_n = RX_STOP;
                else                rx_idx_n   = rx_idx + 1'b1;
            end
            RX_STOP: begin
                if (rx_hold) begin
                    rx_cnt_n = rx_cnt;
                    if (rxd_sync) begin
                        rx_state_n = RX_IDLE;
                        rx_hold_n  = 1'b0;
                    end
                end else if (rx_tick) begin
                    rx_cnt_n = '0;
                    if (rxd_sync) begin
                        rx_push    = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_ferr   = 1'b1;
                        rx_hold_n = 1'b1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    logic [$clog2(RX_FIFO_DEPTH):0] fifo_count;
    logic                           fifo_full;
    logic                           fifo_empty;

    uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .W     (UART_DATA_W)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_re),
        .head      (rx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid = (fifo_count != '0);

`ifdef UART_STATUS_EN
    logic rx_drop;
    assign rx_drop = rx_push && fifo_full && !(rx_re && !fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_drop)      rx_overrun   <= 1'b1;
            else if (err_clr) rx_overrun   <= 1'b0;
            if (rx_ferr)      rx_frame_err <= 1'b1;
            else if (err_clr) rx_frame_err <= 1'b0;
        end
    end
`else
    logic unused_status;
    assign unused_status = fifo_full ^ fifo_empty ^ rx_ferr;
`endif

endmodule

// File: tb/tb_uart_periph.sv
// tb/tb_uart_periph.sv - randomized self-checking bench for uart_periph against a byte-queue model
module tb_uart_periph;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_we = 1'b0;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_re = 1'b0;
    logic       uart_txd;
    logic       uart_rxd;
    logic       loop_en = 1'b0;
    logic       rxd_drv = 1'b1;
`ifdef UART_STATUS_EN
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       err_clr = 1'b0;
    logic       exp_ovr = 1'b0;
    logic       exp_ferr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] model_q[$];

    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    always #5 clk = ~clk;

    uart_periph #(
        .CLKS_PER_BIT  (CPB),
        .RX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_we    (tx_we),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_re    (rx_re),
        .uart_txd (uart_txd),
        .uart_rxd (uart_rxd)
`ifdef UART_STATUS_EN
        ,
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .err_clr      (err_clr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
`ifdef UART_STATUS_EN
        else exp_ovr = 1'b1;
`endif
    endtask

    task automatic check_flags();
`ifdef UART_STATUS_EN
        check("rx_overrun", rx_overrun, exp_ovr);
        check("rx_frame_err", rx_frame_err, exp_ferr);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        check("overrun_clr", rx_overrun, 1'b0);
        check("frame_err_clr", rx_frame_err, 1'b0);
`endif
    endtask

    // Transmit one byte; verify the line every cycle of the 10-bit frame and the busy window.
    task automatic tx_frame(input logic [7:0] d, input bit inject);
        logic [9:0] frame;
        frame = {1'b1, d, 1'b0};
        @(negedge clk);
        tx_data = d;
        tx_we = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10 * CPB; k++) begin
            check("tx_line", uart_txd, frame[k / CPB]);
            check("tx_busy", tx_busy, 1'b1);
            if (inject && k == 10) begin
                tx_data = 8'h3C;
                tx_we = 1'b1;
            end else begin
                tx_we = 1'b0;
            end
            @(negedge clk);
        end
        check("tx_busy_end", tx_busy, 1'b0);
        check("tx_idle_line", uart_txd, 1'b1);
    endtask

    // Drive one serial frame; optionally pop exactly on the cycle the stop bit is sampled
    // (2 sync stages + half a bit + 9 bits after the start edge).
    task automatic rx_send(input logic [7:0] d, input bit stop_bit, input bit pop_at_end);
        logic [9:0] frame;
        frame = {stop_bit, d, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            rxd_drv = frame[k / CPB];
        end
        @(negedge clk);
        rxd_drv = 1'b1;
        if (pop_at_end) begin
            check("pop_same_valid", rx_valid, 1'b1);
            check("pop_same_data", rx_data, model_q[0]);
            rx_re = 1'b1;
        end
        @(negedge clk);
        rx_re = 1'b0;
        if (pop_at_end) void'(model_q.pop_front());
        if (stop_bit) model_push(d);
`ifdef UART_STATUS_EN
        else exp_ferr = 1'b1;
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic drain();
        while (model_q.size() > 0) begin
            check("rx_valid", rx_valid, 1'b1);
            check("rx_data", rx_data, model_q[0]);
            rx_re = 1'b1;
            void'(model_q.pop_front());
            @(negedge clk);
        end
        rx_re = 1'b0;
        check("empty_valid", rx_valid, 1'b0);
        check("empty_data", rx_data, 8'h00);
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
        check("pop_empty_noop", rx_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        tx_frame(8'hA5, 1'b1);
        check("no_rx_without_loop", rx_valid, 1'b0);

        loop_en = 1'b1;
        tx_frame(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        model_push(8'h5A);
        tx_frame(8'hFF, 1'b0);
        repeat (8) @(negedge clk);
        model_push(8'hFF);
        drain();
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            tx_frame(d, 1'b0);
            repeat (8) @(negedge clk);
            model_push(d);
            drain();
        end
        loop_en = 1'b0;
        repeat (4) @(negedge clk);

        rxd_drv = 1'b0;
        @(negedge clk);
        rxd_drv = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_no_push", rx_valid, 1'b0);
        d = 8'($urandom);
        rx_send(d, 1'b1, 1'b0);
        drain();

        rx_send(8'h81, 1'b0, 1'b0);
        check("ferr_no_push", rx_valid, 1'b0);
        check_flags();

        for (int i = 1; i <= 5; i++) rx_send(8'(i), 1'b1, 1'b0);
        check_flags();
        drain();
        for (int i = 1; i <= 5; i++) rx_send(8'(i), 1'b1, i == 5);
        check_flags();
        drain();

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            rx_send(d, $urandom_range(0, 3) != 0, 1'b0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        check_flags();
        drain();

        rx_send(8'h33, 1'b1, 1'b0);
        loop_en = 1'b1;
        @(negedge clk);
        tx_data = 8'hC7;
        tx_we = 1'b1;
        @(negedge clk);
        tx_we = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_txd", uart_txd, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_valid", rx_valid, 1'b0);
        check("midrst_data", rx_data, 8'h00);
        model_q.delete();
`ifdef UART_STATUS_EN
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tx_frame(8'h42, 1'b0);
        repeat (8) @(negedge clk);
        model_push(8'h42);
        drain();
        check_flags();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
